// File: rtl/reg_bank32_pkg.sv
// Shared constants for the 32-entry register bank and its write decoder.
package reg_bank32_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SIZE  = 5;
  localparam int unsigned ZERO_REG  = 0;

endpackage : reg_bank32_pkg

// File: rtl/reg_bank32_reg_decoder.sv
// One-hot write-enable decoder: selects at most one live register per edge.
module reg_decoder
  import reg_bank32_pkg::*;
#(
  parameter int unsigned SIZE = DEF_SIZE
) (
  input  logic                 en,
  input  logic [SIZE-1:0]      addr,
  output logic [REG_COUNT-1:0] sel_c
);

  // Decode the address into a one-hot enable; the zero register is never selected.
  always_comb begin
    sel_c = '0;
    for (int unsigned k = 0; k < REG_COUNT; k++) begin
      if (en && (k != ZERO_REG) && (addr == SIZE'(k))) begin
        sel_c[k] = 1'b1;
      end
    end
  end

endmodule : reg_decoder

// File: rtl/reg_bank32.sv
// 32-entry register bank with a two-stage (capture, then commit) write path.
// Register 0 reads as zero; contents are exposed flat for downstream read muxes.
module reg_bank32
  import reg_bank32_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SIZE  = DEF_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [SIZE-1:0]            wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH*REG_COUNT-1:0] data_flat,
  output logic                       pend_valid,
  output logic [SIZE-1:0]            pend_addr,
  output logic [WIDTH-1:0]           pend_data,
  output logic [REG_COUNT-1:0]       written
);

  logic             accept_c;
  logic [REG_COUNT-1:0] sel_c;

  // Writes aimed at the zero register are dropped before they reach the pipeline.
  assign accept_c = wr_en && (wr_addr != SIZE'(ZERO_REG));

  // Capture stage: latch an accepted write; address/data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= accept_c;
      if (accept_c) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  reg_decoder #(
    .SIZE (SIZE)
  ) u_decoder (
    .en    (pend_valid),
    .addr  (pend_addr),
    .sel_c (sel_c)
  );

  // Sticky record of which registers have been committed since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= '0;
    end else begin
      written <= written | sel_c;
    end
  end

  // Commit stage: per-register storage, each loaded by its one-hot enable.
  for (genvar k = 0; k < REG_COUNT; k++) begin : g_reg
    if (k == ZERO_REG) begin : g_zero
      assign data_flat[WIDTH*k +: WIDTH] = '0;
    end else begin : g_live
      logic [WIDTH-1:0] q;

      // Load the pending data when this register is the commit target.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (sel_c[k]) begin
          q <= pend_data;
        end
      end

      assign data_flat[WIDTH*k +: WIDTH] = q;
    end
  end

endmodule : reg_bank32

// File: tb/tb_reg_bank32.sv
// Self-checking bench for reg_bank32: directed scenarios plus random writes
// compared against a behavioural model of the register file.
module tb_reg_bank32;

  localparam int unsigned W = 32;
  localparam int unsigned S = 5;
  localparam int unsigned N = 32;

  logic           clk;
  logic           rst_n;
  logic           wr_en;
  logic [S-1:0]   wr_addr;
  logic [W-1:0]   wr_data;
  logic [W*N-1:0] data_flat;
  logic           pend_valid;
  logic [S-1:0]   pend_addr;
  logic [W-1:0]   pend_data;
  logic [N-1:0]   written;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: register contents, committed flags, and the queue of
  // accepted writes that have not yet become visible.
  logic [W-1:0] m_reg [N];
  logic [N-1:0] m_written;
  typedef struct packed {
    logic [S-1:0] addr;
    logic [W-1:0] data;
  } wr_t;
  wr_t          m_queue[$];
  logic [S-1:0] m_last_addr;
  logic [W-1:0] m_last_data;

  reg_bank32 #(.WIDTH(W), .SIZE(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .data_flat  (data_flat),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .pend_data  (pend_data),
    .written    (written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input int k);
    return data_flat[W*k +: W];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < int'(N); k++) m_reg[k] = '0;
    m_written   = '0;
    m_queue.delete();
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  // Compare every observable against the model.
  task automatic check_all(input string tag);
    for (int k = 0; k < int'(N); k++)
      check($sformatf("%s_slice%0d", tag, k), 64'(slice(k)), 64'(m_reg[k]));
    check({tag, "_written"}, 64'(written), 64'(m_written));
    check({tag, "_pend_valid"}, 64'(pend_valid), 64'(m_queue.size() != 0));
    check({tag, "_pend_addr"}, 64'(pend_addr), 64'(m_last_addr));
    check({tag, "_pend_data"}, 64'(pend_data), 64'(m_last_data));
  endtask

  // One clock: present a request, let the edge happen, advance the model.
  // A write accepted at one edge becomes visible at the following edge.
  task automatic cycle(input logic en, input logic [S-1:0] addr, input logic [W-1:0] data);
    wr_t w;
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    while (m_queue.size() != 0) begin
      w = m_queue.pop_front();
      m_reg[w.addr]     = w.data;
      m_written[w.addr] = 1'b1;
    end
    if (en && addr != 0) begin
      m_queue.push_back('{addr: addr, data: data});
      m_last_addr = addr;
      m_last_data = data;
    end
  endtask

  // Assert reset between edges, verify it takes effect with no clock, release mid-cycle.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Single write to register 5.
    cycle(1'b1, 5'd5, 32'hDEADBEEF);
    check("w5_pend_valid", 64'(pend_valid), 64'd1);
    check("w5_pend_addr", 64'(pend_addr), 64'd5);
    check("w5_not_yet", 64'(slice(5)), 64'd0);
    cycle(1'b0, 5'd0, 32'h0);
    check("w5_slice", 64'(slice(5)), 64'hDEADBEEF);
    check("w5_written", 64'(written), 64'h20);
    check("w5_pend_drop", 64'(pend_valid), 64'd0);
    check_all("single");

    // Writes to the zero register are discarded.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF);
    check("z_pend_valid", 64'(pend_valid), 64'd0);
    cycle(1'b0, 5'd0, 32'h0);
    check("z_slice0", 64'(slice(0)), 64'd0);
    check("z_written0", 64'(written[0]), 64'd0);
    check_all("zero");

    // Back-to-back writes, last one to a given address wins.
    cycle(1'b1, 5'd7, 32'd1);
    cycle(1'b1, 5'd7, 32'd2);
    cycle(1'b1, 5'd31, 32'd3);
    cycle(1'b0, 5'd0, 32'h0);
    check("b2b_slice7", 64'(slice(7)), 64'd2);
    check("b2b_slice31", 64'(slice(31)), 64'd3);
    check("b2b_written", 64'(written), 64'h800000A0);
    check_all("b2b");

    // Reset with a write still pending discards it.
    cycle(1'b1, 5'd9, 32'h55);
    check("rp_pend_valid", 64'(pend_valid), 64'd1);
    async_reset("rp_reset");
    cycle(1'b0, 5'd0, 32'h0);
    check("rp_slice9", 64'(slice(9)), 64'd0);
    check("rp_written9", 64'(written[9]), 64'd0);
    check_all("rp");

    // Sweep every live address.
    for (int k = 1; k < int'(N); k++) cycle(1'b1, S'(k), W'(k));
    cycle(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < int'(N); k++)
      check($sformatf("sweep_k%0d", k), 64'(slice(k)), 64'(k));
    check("sweep_written", 64'(written), 64'hFFFFFFFE);
    check_all("sweep");

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 3) != 0), S'($urandom_range(0, 31)), W'($urandom));
      check_all("rand");
    end

    // Reset in the middle of traffic.
    cycle(1'b1, 5'd12, 32'hA5A5A5A5);
    async_reset("mid_reset");
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 1) != 0), S'($urandom_range(0, 31)), W'($urandom));
      check_all("rand2");
    end
    cycle(1'b0, 5'd0, 32'h0);
    cycle(1'b0, 5'd0, 32'h0);
    check_all("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_reg_bank32
